regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU decode/writeback boundary. It provides NREAD synchronous read ports, two write ports (ALU and memory writeback), write-through bypass and a per-register busy scoreboard for hazard detection. Storage, read outputs and the scoreboard reset asynchronously. It replaces the fixed 32x32, 2-read/1-write register file.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bundle of write, read, and scoreboard signals between the decode/writeback logic and the register file.
// The register file takes the slave side; the issuing or writeback logic (or a bench) takes the master side.
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                   we0;
    logic [AW-1:0]          windex0;
    logic [WIDTH-1:0]       win0;
    logic                   we1;
    logic [AW-1:0]          windex1;
    logic [WIDTH-1:0]       win1;
    logic [NREAD*AW-1:0]    rindex;
    logic [NREAD*WIDTH-1:0] rout;
    logic [NREAD-1:0]       rbusy;
    logic                   set_en;
    logic [AW-1:0]          set_index;
    logic                   flush;

    modport master (
        output we0, windex0, win0, we1, windex1, win1, rindex, set_en, set_index, flush,
        input  rout, rbusy
    );

    modport slave (
        input  we0, windex0, win0, we1, windex1, win1, rindex, set_en, set_index, flush,
        output rout, rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports (port 1 wins), write-through reads and a busy scoreboard.
// Read latency is 1 cycle; no backpressure, every input is sampled on every edge.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    logic [WIDTH-1:0]       store [DEPTH];
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       busy_nxt;
    logic                   wr0;
    logic                   wr1;
    logic [NREAD*WIDTH-1:0] rout_nxt;
    logic [NREAD*WIDTH-1:0] rout_q;
    logic [NREAD-1:0]       rbusy_nxt;
    logic [NREAD-1:0]       rbusy_q;

    // Writes to the hard-wired zero register are dropped here, so they neither store nor clear busy.
    assign wr0 = bus.we0 && !(ZERO_REG && (bus.windex0 == '0));
    assign wr1 = bus.we1 && !(ZERO_REG && (bus.windex1 == '0));

    // A set on an index beats a retiring write on the same index: the new producer owns the register.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush)
                busy_nxt[i] = 1'b0;
            else if (bus.set_en && (bus.set_index == AW'(i)))
                busy_nxt[i] = 1'b1;
            else if ((wr0 && (bus.windex0 == AW'(i))) || (wr1 && (bus.windex1 == AW'(i))))
                busy_nxt[i] = 1'b0;
        end
        if (ZERO_REG)
            busy_nxt[0] = 1'b0;
    end

    // Each port reads the array once and muxes in same-edge write data.
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        rout_nxt  = '0;
        rbusy_nxt = '0;
        for (int k = 0; k < NREAD; k++) begin
            idx = bus.rindex[k*AW +: AW];
            if (ZERO_REG && (idx == '0))
                rout_nxt[k*WIDTH +: WIDTH] = '0;
            else if (wr1 && (bus.windex1 == idx))
                rout_nxt[k*WIDTH +: WIDTH] = bus.win1;
            else if (wr0 && (bus.windex0 == idx))
                rout_nxt[k*WIDTH +: WIDTH] = bus.win0;
            else
                rout_nxt[k*WIDTH +: WIDTH] = store[idx];
            rbusy_nxt[k] = busy_nxt[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                store[i] <= '0;
            busy    <= '0;
            rout_q  <= '0;
            rbusy_q <= '0;
        end else begin
            if (wr0)
                store[bus.windex0] <= bus.win0;
            // Issued after port 0 so a same-index write resolves to port 1.
            if (wr1)
                store[bus.windex1] <= bus.win1;
            busy    <= busy_nxt;
            rout_q  <= rout_nxt;
            rbusy_q <= rbusy_nxt;
        end
    end

    assign bus.rout  = rout_q;
    assign bus.rbusy = rbusy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector table on a 32x32/2-port zero-register instance plus reset and random model checks on an 8x16/3-port instance without a zero register.
module tb_regfile_mp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_mp_if #(.WIDTH(32), .AW(5), .NREAD(2)) ia ();
    regfile_mp_if #(.WIDTH(8),  .AW(4), .NREAD(3)) ib ();

    regfile_mp #(.WIDTH(32), .DEPTH(32), .AW(5), .NREAD(2), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    regfile_mp #(.WIDTH(8), .DEPTH(16), .AW(4), .NREAD(3), .ZERO_REG(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wi0;
        logic [31:0] w0;
        logic        we1;
        logic [4:0]  wi1;
        logic [31:0] w1;
        logic        set;
        logic [4:0]  si;
        logic        flush;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(logic we0, logic [4:0] wi0, logic [31:0] w0,
                                logic we1, logic [4:0] wi1, logic [31:0] w1,
                                logic set, logic [4:0] si, logic flush,
                                logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic b0, logic b1);
        vec_t v;
        v.we0 = we0; v.wi0 = wi0; v.w0 = w0;
        v.we1 = we1; v.wi1 = wi1; v.w1 = w1;
        v.set = set; v.si = si; v.flush = flush;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        ia.we0 = 0; ia.windex0 = '0; ia.win0 = '0;
        ia.we1 = 0; ia.windex1 = '0; ia.win1 = '0;
        ia.set_en = 0; ia.set_index = '0; ia.flush = 0; ia.rindex = '0;
    endtask

    task automatic idle_b();
        ib.we0 = 0; ib.windex0 = '0; ib.win0 = '0;
        ib.we1 = 0; ib.windex1 = '0; ib.win1 = '0;
        ib.set_en = 0; ib.set_index = '0; ib.flush = 0; ib.rindex = '0;
    endtask

    logic [7:0]  st_m [16];
    logic [15:0] busy_m;
    logic [3:0]  ri [3];
    logic [23:0] exp_rout;
    logic [2:0]  exp_rbusy;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_a();
        idle_b();

        vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,  5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vt[1]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  5, 0,  32'hDEADBEEF, 32'h0,        0, 0);
        vt[2]  = mk(1, 7, 32'h11,       1, 7, 32'h22,   0, 0, 0,  7, 7,  32'h22,       32'h22,       0, 0);
        vt[3]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,        1, 0, 0,  0, 5,  32'h0,        32'hDEADBEEF, 0, 0);
        vt[4]  = mk(0, 0, 0,            0, 0, 0,        1, 3, 0,  3, 7,  32'h0,        32'h22,       1, 0);
        vt[5]  = mk(0, 0, 0,            1, 3, 32'h33,   0, 0, 0,  3, 3,  32'h33,       32'h33,       0, 0);
        vt[6]  = mk(1, 3, 32'h44,       0, 0, 0,        1, 3, 0,  3, 3,  32'h44,       32'h44,       1, 1);
        vt[7]  = mk(0, 0, 0,            0, 0, 0,        1, 4, 0,  4, 3,  32'h0,        32'h44,       1, 1);
        vt[8]  = mk(0, 0, 0,            0, 0, 0,        1, 9, 0,  9, 4,  32'h0,        32'h0,        1, 1);
        vt[9]  = mk(0, 0, 0,            0, 0, 0,        1, 4, 1,  4, 9,  32'h0,        32'h0,        0, 0);
        vt[10] = mk(1, 2, 32'hAA,       1, 6, 32'hBB,   0, 0, 0,  6, 2,  32'hBB,       32'hAA,       0, 0);
        vt[11] = mk(0, 0, 0,            0, 0, 0,        0, 0, 0,  7, 2,  32'h22,       32'hAA,       0, 0);

        #12;
        chk("reset_a_rout",  64'(ia.rout),  64'h0);
        chk("reset_a_rbusy", 64'(ia.rbusy), 64'h0);
        chk("reset_b_rout",  64'(ib.rout),  64'h0);
        chk("reset_b_rbusy", 64'(ib.rbusy), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            ia.we0 = vt[v].we0; ia.windex0 = vt[v].wi0; ia.win0 = vt[v].w0;
            ia.we1 = vt[v].we1; ia.windex1 = vt[v].wi1; ia.win1 = vt[v].w1;
            ia.set_en = vt[v].set; ia.set_index = vt[v].si; ia.flush = vt[v].flush;
            ia.rindex = {vt[v].r1, vt[v].r0};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rout0", v),  64'(ia.rout[31:0]),  64'(vt[v].e0));
            chk($sformatf("vec%0d_rout1", v),  64'(ia.rout[63:32]), 64'(vt[v].e1));
            chk($sformatf("vec%0d_rbusy0", v), 64'(ia.rbusy[0]),    64'(vt[v].b0));
            chk($sformatf("vec%0d_rbusy1", v), 64'(ia.rbusy[1]),    64'(vt[v].b1));
        end
        idle_a();

        // Without a zero register, r0 stores data and can be marked busy.
        ib.we0 = 1; ib.windex0 = 4'd0; ib.win0 = 8'hFF;
        ib.set_en = 1; ib.set_index = 4'd0; ib.rindex = '0;
        @(posedge clk);
        #1;
        chk("z0_rout",  64'(ib.rout),  64'hFFFFFF);
        chk("z0_rbusy", 64'(ib.rbusy), 64'h7);
        idle_b();

        // Asynchronous reset with nonzero contents, held across an edge.
        ia.rindex = {5'd7, 5'd6};
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rout",  64'(ia.rout),  64'h0);
        @(posedge clk);
        #1;
        chk("held_rst_rout",   64'(ia.rout),  64'h0);
        chk("held_rst_rbusy",  64'(ia.rbusy), 64'h0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ia.rindex = {5'(31 - i), 5'(i)};
            @(posedge clk);
            #1;
            chk($sformatf("clr_rout_r%0d", i),  64'(ia.rout),  64'h0);
            chk($sformatf("clr_rbusy_r%0d", i), 64'(ia.rbusy), 64'h0);
        end

        for (int i = 0; i < 16; i++) st_m[i] = '0;
        busy_m = '0;
        for (int c = 0; c < 300; c++) begin
            ib.we0 = 1'($urandom_range(0, 1));
            ib.windex0 = 4'($urandom_range(0, 7));
            ib.win0 = 8'($urandom);
            ib.we1 = 1'($urandom_range(0, 1));
            ib.windex1 = 4'($urandom_range(0, 7));
            ib.win1 = 8'($urandom);
            ib.set_en = 1'($urandom_range(0, 1));
            ib.set_index = 4'($urandom_range(0, 7));
            ib.flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < 3; k++) ri[k] = 4'($urandom_range(0, 8));
            ib.rindex = {ri[2], ri[1], ri[0]};

            for (int i = 0; i < 16; i++) begin
                if (ib.flush) busy_m[i] = 1'b0;
                else if (ib.set_en && ib.set_index == 4'(i)) busy_m[i] = 1'b1;
                else if ((ib.we0 && ib.windex0 == 4'(i)) || (ib.we1 && ib.windex1 == 4'(i)))
                    busy_m[i] = 1'b0;
            end
            if (ib.we0) st_m[ib.windex0] = ib.win0;
            if (ib.we1) st_m[ib.windex1] = ib.win1;
            for (int k = 0; k < 3; k++) begin
                exp_rout[k*8 +: 8] = st_m[ri[k]];
                exp_rbusy[k]       = busy_m[ri[k]];
            end

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_rout", c),  64'(ib.rout),  64'(exp_rout));
            chk($sformatf("rnd%0d_rbusy", c), 64'(ib.rbusy), 64'(exp_rbusy));

            if ($urandom_range(0, 24) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk($sformatf("rnd%0d_rst_rout", c),  64'(ib.rout),  64'h0);
                chk($sformatf("rnd%0d_rst_rbusy", c), 64'(ib.rbusy), 64'h0);
                rst = 1'b0;
                for (int i = 0; i < 16; i++) st_m[i] = '0;
                busy_m = '0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
